sm_trace_buffer: RTL and testbench

- On-chip execution trace recorder for the schoolMIPS core.
- Samples PC, instruction word and CH watched register values once per qualified CPU step into a circular buffer.
- Arms, triggers on one of several conditions, then captures a post-trigger window; also fires a cycle-budget watchdog.
- Sits beside sm_cpu in sm_top; a debug host reads the buffer back through an indexed read port.

---
 rtl/sm_trace_buffer_pkg.sv | 23 ++
 rtl/sm_trace_ram.sv | 24 ++
 rtl/sm_trace_buffer.sv | 197 +++++++++++++++++++
 tb/tb_sm_trace_buffer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_trace_buffer_pkg.sv
// Shared encodings for the schoolMIPS execution trace recorder.
// Covers the capture states, the trigger modes and the readout field codes.
package sm_trace_buffer_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StArmed = 2'b01,
    StPost  = 2'b10,
    StDone  = 2'b11
  } traceStateT;

  typedef enum logic [1:0] {
    TrigImm      = 2'b00,
    TrigPc       = 2'b01,
    TrigOpcode   = 2'b10,
    TrigWatchdog = 2'b11
  } trigModeT;

  localparam logic [3:0] RF_PC    = 4'd0;
  localparam logic [3:0] RF_INSTR = 4'd1;
  localparam logic [3:0] RF_CH0   = 4'd2;

endpackage

// File: rtl/sm_trace_ram.sv
// Simple dual-port trace storage: synchronous write, registered read.
// A read and a write to the same address in one cycle return the old word.
module sm_trace_ram #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [DATA_W-1:0] wData,
  input  logic [ADDR_W-1:0] rAddr,
  output logic [DATA_W-1:0] rData
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wAddr] <= wData;
    end
    rData <= mem[rAddr];
  end

endmodule

// File: rtl/sm_trace_buffer.sv
// Execution trace recorder: samples pc/instr/watched channels per CPU step into a
// circular buffer, triggers on a selectable condition and keeps a post-trigger window.
module sm_trace_buffer
  import sm_trace_buffer_pkg::*;
#(
  parameter int unsigned DEPTH_LOG = 4,
  parameter int unsigned CH        = 2,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 capEn,
  input  logic [31:0]          pc,
  input  logic [31:0]          instr,
  input  logic [CH*32-1:0]     chData,
  input  logic                 arm,
  input  logic [1:0]           trigMode,
  input  logic [31:0]          trigValue,
  input  logic [DEPTH_LOG-1:0] postCount,
  input  logic [TIMEOUT_W-1:0] timeout,
  input  logic [DEPTH_LOG-1:0] rdIdx,
  input  logic [3:0]           rdField,
  output logic [31:0]          rdData,
  output logic [1:0]           state,
  output logic                 triggered,
  output logic                 timedOut,
  output logic [DEPTH_LOG:0]   count
);

  localparam int unsigned ENTRY_W = 64 + 32 * CH;
  localparam logic [DEPTH_LOG:0] COUNT_MAX = {1'b1, {DEPTH_LOG{1'b0}}};
  localparam logic [4:0] FIELD_LIMIT = 5'(RF_CH0) + 5'(CH);

  traceStateT stateQ, stateD;
  trigModeT modeQ, modeD;
  logic [DEPTH_LOG-1:0] wptrQ, wptrD;
  logic [DEPTH_LOG:0] countQ, countD;
  logic [DEPTH_LOG-1:0] postCntQ, postCntD;
  logic [DEPTH_LOG-1:0] postCountQ, postCountD;
  logic [TIMEOUT_W-1:0] stepQ, stepD;
  logic trigQ, trigD;
  logic toQ, toD;

  logic we;
  logic modeMatch;
  logic wdFire;
  logic [TIMEOUT_W-1:0] stepInc;
  logic [DEPTH_LOG:0] countInc;
  logic [DEPTH_LOG-1:0] postCntInc;

  logic [ENTRY_W-1:0] wEntry;
  logic [ENTRY_W-1:0] ramQ;
  logic [DEPTH_LOG-1:0] rdAddr;
  logic rdOk;
  logic validQ;
  logic [3:0] fieldQ;

  assign wEntry     = {chData, instr, pc};
  assign stepInc    = (stepQ == '1) ? stepQ : stepQ + 1'b1;
  assign countInc   = (countQ == COUNT_MAX) ? countQ : countQ + 1'b1;
  assign postCntInc = postCntQ + 1'b1;
  // Watchdog compares the step count including the current sample.
  assign wdFire     = (timeout != '0) && (stepInc == timeout);

  always_comb begin
    modeMatch = 1'b0;
    unique case (modeQ)
      TrigImm:      modeMatch = 1'b1;
      TrigPc:       modeMatch = (pc == trigValue);
      TrigOpcode:   modeMatch = (instr[31:26] == trigValue[5:0]);
      TrigWatchdog: modeMatch = 1'b0;
      default:      modeMatch = 1'b0;
    endcase
  end

  always_comb begin
    stateD     = stateQ;
    modeD      = modeQ;
    wptrD      = wptrQ;
    countD     = countQ;
    postCntD   = postCntQ;
    postCountD = postCountQ;
    stepD      = stepQ;
    trigD      = trigQ;
    toD        = toQ;
    we         = 1'b0;

    if (arm) begin
      stateD     = StArmed;
      modeD      = trigModeT'(trigMode);
      postCountD = postCount;
      wptrD      = '0;
      countD     = '0;
      postCntD   = '0;
      stepD      = '0;
      trigD      = 1'b0;
      toD        = 1'b0;
    end else if (capEn) begin
      unique case (stateQ)
        StArmed: begin
          we     = 1'b1;
          wptrD  = wptrQ + 1'b1;
          countD = countInc;
          stepD  = stepInc;
          if (modeMatch || wdFire) begin
            trigD  = 1'b1;
            toD    = ~modeMatch;
            stateD = (postCountQ == '0) ? StDone : StPost;
          end
        end
        StPost: begin
          we       = 1'b1;
          wptrD    = wptrQ + 1'b1;
          countD   = countInc;
          postCntD = postCntInc;
          if (postCntInc == postCountQ) begin
            stateD = StDone;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ     <= StIdle;
      modeQ      <= TrigImm;
      wptrQ      <= '0;
      countQ     <= '0;
      postCntQ   <= '0;
      postCountQ <= '0;
      stepQ      <= '0;
      trigQ      <= 1'b0;
      toQ        <= 1'b0;
    end else begin
      stateQ     <= stateD;
      modeQ      <= modeD;
      wptrQ      <= wptrD;
      countQ     <= countD;
      postCntQ   <= postCntD;
      postCountQ <= postCountD;
      stepQ      <= stepD;
      trigQ      <= trigD;
      toQ        <= toD;
    end
  end

  // Oldest valid entry sits count slots behind the write pointer.
  assign rdAddr = wptrQ - countQ[DEPTH_LOG-1:0] + rdIdx;
  assign rdOk   = ({1'b0, rdIdx} < countQ) && ({1'b0, rdField} < FIELD_LIMIT);

  sm_trace_ram #(
    .ADDR_W(DEPTH_LOG),
    .DATA_W(ENTRY_W)
  ) uRam (
    .clk  (clk),
    .we   (we),
    .wAddr(wptrQ),
    .wData(wEntry),
    .rAddr(rdAddr),
    .rData(ramQ)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validQ <= 1'b0;
      fieldQ <= RF_PC;
    end else begin
      validQ <= rdOk;
      fieldQ <= rdField;
    end
  end

  always_comb begin
    rdData = '0;
    if (validQ) begin
      if (fieldQ == RF_PC) begin
        rdData = ramQ[31:0];
      end else if (fieldQ == RF_INSTR) begin
        rdData = ramQ[63:32];
      end else begin
        for (int k = 0; k < int'(CH); k++) begin
          if (fieldQ == 4'(RF_CH0 + 4'(k))) begin
            rdData = ramQ[64 + 32 * k +: 32];
          end
        end
      end
    end
  end

  assign state     = stateQ;
  assign triggered = trigQ;
  assign timedOut  = toQ;
  assign count     = countQ;

endmodule

// File: tb/tb_sm_trace_buffer.sv
// Self-checking bench for sm_trace_buffer: directed scenarios plus randomized captures,
// compared each cycle against a queue-based model of the recorded history.
module tb_sm_trace_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        capEn;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [63:0] chData;
  logic        arm;
  logic [1:0]  trigMode;
  logic [31:0] trigValue;
  logic [3:0]  postCount;
  logic [15:0] timeout;
  logic [3:0]  rdIdx;
  logic [3:0]  rdField;
  logic [31:0] rdData;
  logic [1:0]  state;
  logic        triggered;
  logic        timedOut;
  logic [4:0]  count;

  sm_trace_buffer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .capEn    (capEn),
    .pc       (pc),
    .instr    (instr),
    .chData   (chData),
    .arm      (arm),
    .trigMode (trigMode),
    .trigValue(trigValue),
    .postCount(postCount),
    .timeout  (timeout),
    .rdIdx    (rdIdx),
    .rdField  (rdField),
    .rdData   (rdData),
    .state    (state),
    .triggered(triggered),
    .timedOut (timedOut),
    .count    (count)
  );

  always #5 clk = ~clk;

  // Model: history of samples since arm (last 16 kept), plus capture bookkeeping.
  typedef logic [127:0] entryT;
  entryT mBuf[$];
  int    mState, mSteps, mPost, mPostCount, mMode;
  bit    mTrig, mTo;
  int    nTests = 0;
  int    nFail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mState = 0; mSteps = 0; mPost = 0; mPostCount = 0; mMode = 0;
    mTrig = 0; mTo = 0;
    mBuf.delete();
  endtask

  function automatic logic [31:0] modelRead(input int idx, input int field);
    entryT e;
    if (idx >= mBuf.size()) return 32'h0;
    e = mBuf[idx];
    case (field)
      0: return e[31:0];
      1: return e[63:32];
      2: return e[95:64];
      3: return e[127:96];
      default: return 32'h0;
    endcase
  endfunction

  task automatic modelEdge();
    bit hit, wd;
    if (arm) begin
      modelReset();
      mState = 1;
      mPostCount = int'(postCount);
      mMode = int'(trigMode);
    end else if (capEn && (mState == 1 || mState == 2)) begin
      mBuf.push_back({chData, instr, pc});
      if (mBuf.size() > 16) mBuf.delete(0);
      if (mState == 1) begin
        if (mSteps < 65535) mSteps++;
        hit = (mMode == 0) || (mMode == 1 && pc == trigValue) ||
              (mMode == 2 && instr[31:26] == trigValue[5:0]);
        wd = (timeout != 0) && (mSteps == int'(timeout));
        if (hit || wd) begin
          mTrig = 1;
          mTo = !hit;
          mState = (mPostCount == 0) ? 3 : 2;
        end
      end else begin
        mPost++;
        if (mPost == mPostCount) mState = 3;
      end
    end
  endtask

  task automatic chkAll(input logic [31:0] expRd);
    chk("state", 32'(state), 32'(mState));
    chk("count", 32'(count), 32'(mBuf.size()));
    chk("triggered", 32'(triggered), 32'(mTrig));
    chk("timedOut", 32'(timedOut), 32'(mTo));
    chk("rdData", rdData, expRd);
  endtask

  task automatic tick();
    logic [31:0] expRd;
    expRd = modelRead(int'(rdIdx), int'(rdField));
    modelEdge();
    @(posedge clk);
    #1;
    chkAll(expRd);
  endtask

  task automatic step(input logic c, input logic [31:0] p, input logic [31:0] i);
    capEn = c; pc = p; instr = i;
    chData = {$urandom, $urandom};
    tick();
    capEn = 1'b0;
  endtask

  task automatic doArm(input logic [1:0] m, input logic [31:0] tv, input logic [3:0] pcnt,
                       input logic [15:0] to);
    arm = 1'b1; trigMode = m; trigValue = tv; postCount = pcnt; timeout = to;
    capEn = 1'b1;
    tick();
    arm = 1'b0; capEn = 1'b0;
  endtask

  task automatic readAt(input logic [3:0] idx, input logic [3:0] fld);
    rdIdx = idx; rdField = fld;
    tick();
  endtask

  initial begin
    logic [31:0] seqPc;
    rst_n = 1'b0; capEn = 1'b0; pc = '0; instr = '0; chData = '0; arm = 1'b0;
    trigMode = '0; trigValue = '0; postCount = '0; timeout = '0; rdIdx = '0; rdField = '0;
    modelReset();
    #12;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_trig", 32'(triggered), 32'd0);
    chk("rst_rd", rdData, 32'd0);
    rst_n = 1'b1;
    step(1'b1, 32'h55, 32'h0);  // IDLE ignores samples

    // Immediate trigger, 3 post samples.
    doArm(2'b00, 32'h0, 4'd3, 16'd0);
    for (int i = 0; i < 10; i++) step(1'b1, 32'(i), $urandom);
    chk("m0_state", 32'(state), 32'd3);
    chk("m0_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      readAt(4'(i), 4'd0);
      chk("m0_read", rdData, 32'(i));
    end
    readAt(4'd4, 4'd0);
    readAt(4'd1, 4'd9);

    // PC match with wrapped pre-trigger history.
    doArm(2'b01, 32'd20, 4'd2, 16'd0);
    for (int i = 0; i <= 40; i++) step(1'b1, 32'(i), $urandom);
    chk("m1_state", 32'(state), 32'd3);
    chk("m1_count", 32'(count), 32'd16);
    readAt(4'd0, 4'd0);
    chk("m1_oldest", rdData, 32'd7);
    readAt(4'd15, 4'd0);
    chk("m1_newest", rdData, 32'd22);
    for (int f = 1; f < 6; f++) readAt(4'($urandom_range(0, 15)), 4'(f));

    // Opcode match: beq at step 5.
    doArm(2'b10, 32'h4, 4'd2, 16'd0);
    for (int i = 0; i < 10; i++)
      step(1'b1, 32'(100 + i), (i == 5) ? {6'h04, 26'($urandom)} : {6'h23, 26'($urandom)});
    chk("m2_trig", 32'(triggered), 32'd1);
    chk("m2_to", 32'(timedOut), 32'd0);
    readAt(4'(count - 5'd3), 4'd1);
    chk("m2_opc", 32'(rdData[31:26]), 32'h4);

    // Watchdog only.
    doArm(2'b11, 32'h0, 4'd0, 16'd6);
    for (int i = 0; i < 10; i++) step(1'b1, $urandom, $urandom);
    chk("m3_state", 32'(state), 32'd3);
    chk("m3_to", 32'(timedOut), 32'd1);
    chk("m3_count", 32'(count), 32'd6);

    // PC match coinciding with the watchdog: match wins.
    doArm(2'b01, 32'd3, 4'd1, 16'd4);
    for (int i = 0; i < 6; i++) step(1'b1, 32'(i), $urandom);
    chk("coin_to", 32'(timedOut), 32'd0);
    chk("coin_trig", 32'(triggered), 32'd1);

    // Re-arm during POST.
    doArm(2'b00, 32'h0, 4'd5, 16'd0);
    step(1'b1, 32'd1, 32'd0);
    step(1'b1, 32'd2, 32'd0);
    chk("rearm_pre", 32'(state), 32'd2);
    doArm(2'b00, 32'h0, 4'd1, 16'd0);
    chk("rearm_state", 32'(state), 32'd1);
    chk("rearm_count", 32'(count), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'(50 + i), $urandom);
    chk("rearm_done", 32'(count), 32'd2);

    // Async reset mid-POST.
    doArm(2'b00, 32'h0, 4'd8, 16'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'(i), $urandom);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_trig", 32'(triggered), 32'd0);
    chk("arst_rd", rdData, 32'd0);
    modelReset();
    #3 rst_n = 1'b1;
    readAt(4'd0, 4'd0);
    chk("arst_read0", rdData, 32'd0);

    // Randomized captures.
    for (int c = 0; c < 20; c++) begin
      logic [1:0] m;
      m = 2'($urandom_range(0, 3));
      seqPc = 32'd0;
      doArm(m, (m == 2'b10) ? 32'($urandom_range(0, 7)) : 32'($urandom_range(0, 40)),
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 30)));
      for (int t = 0; t < 40; t++) begin
        arm = ($urandom_range(0, 59) == 0);
        if (arm) begin
          trigMode = 2'($urandom_range(0, 3));
          postCount = 4'($urandom_range(0, 15));
        end
        rdIdx = 4'($urandom_range(0, 15));
        rdField = 4'($urandom_range(0, 5));
        step(($urandom_range(0, 3) != 0), seqPc, {6'($urandom_range(0, 7)), 26'($urandom)});
        arm = 1'b0;
        seqPc = seqPc + 32'd1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
